pong_frame_tx: RTL and testbench

//  Transmit end of the inter-board pong link. On each accepted timing_tick, snapshots a
//  32-bit game-state frame {1'b1, y_player1[9:0], y_ball[9:0], x_ball[10:0]} and sends it
//  as 4 UART 8N1 bytes, MSB byte first, so the peer's rx_buf holds the identical frame.

---
 rtl/pong_frame_tx.sv | 129 ++++++++++++
 tb/tb_pong_frame_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pong_frame_tx.sv
// Transmit end of the inter-board pong link: serialises a 32-bit game-state frame
// as four UART 8N1 bytes (MSB byte first) with a built-in bit-timing counter.
module pong_frame_tx #(
  parameter int CLKS_PER_BIT = 564,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        enable,
  input  logic [31:0] frame_in,
  output logic        tx,
  output logic        busy,
  output logic        frame_sent,
  output logic        overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   frame_q, frame_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          frame_sent_q, frame_sent_d;
  logic          overrun_q, overrun_d;
  logic          bit_done;

  assign bit_done = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    byte_idx_d   = byte_idx_q;
    frame_d      = frame_q;
    frame_sent_d = 1'b0;
    overrun_d    = 1'b0;

    if (state_q == IDLE) begin
      if (timing_tick && enable) begin
        frame_d    = frame_in;
        state_d    = START;
        cnt_d      = '0;
        bit_idx_d  = '0;
        byte_idx_d = '0;
      end
    end else begin
      overrun_d = timing_tick && enable;
      if (!bit_done) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
        unique case (state_q)
          START: begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
          DATA: begin
            if (bit_idx_q == 3'd7) begin
              state_d   = STOP;
              bit_idx_d = '0;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
          STOP: begin
            if (bit_idx_q == 3'(STOP_BITS - 1)) begin
              bit_idx_d = '0;
              if (byte_idx_q == 2'd3) begin
                state_d      = IDLE;
                frame_sent_d = 1'b1;
              end else begin
                state_d    = START;
                byte_idx_d = byte_idx_q + 2'd1;
              end
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Outputs are registered, so they are decoded from the next state.
    // Byte k occupies frame bits [31-8k -: 8], i.e. index {~k, bit}.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = frame_d[{~byte_idx_d, bit_idx_d}];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      frame_q      <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_sent_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      frame_q      <= frame_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_sent_q <= frame_sent_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_sent = frame_sent_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pong_frame_tx.sv
// Bench for pong_frame_tx: one instance with one stop bit and one with two, checked
// cycle by cycle against a waveform model built from the UART framing rules.
module tb_pong_frame_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick1, en1, tick2, en2;
  logic [31:0] fin1, fin2;
  logic        tx1, busy1, sent1, ovr1;
  logic        tx2, busy2, sent2, ovr2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pong_frame_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .timing_tick(tick1), .enable(en1), .frame_in(fin1),
    .tx(tx1), .busy(busy1), .frame_sent(sent1), .overrun(ovr1)
  );

  pong_frame_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .timing_tick(tick2), .enable(en2), .frame_in(fin2),
    .tx(tx2), .busy(busy2), .frame_sent(sent2), .overrun(ovr2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic t, input logic e, input logic [31:0] f);
    if (sel) begin tick2 = t; en2 = e; fin2 = f; end
    else     begin tick1 = t; en1 = e; fin1 = f; end
  endtask

  function automatic logic o_tx(input bit sel);   return sel ? tx2   : tx1;   endfunction
  function automatic logic o_busy(input bit sel); return sel ? busy2 : busy1; endfunction
  function automatic logic o_sent(input bit sel); return sel ? sent2 : sent1; endfunction
  function automatic logic o_ovr(input bit sel);  return sel ? ovr2  : ovr1;  endfunction

  // Line level k cycles after the first start-bit cycle of a frame.
  function automatic logic exp_bit(input logic [31:0] f, input int k, input int s);
    int pos = k / CPB;
    int byt = pos / (9 + s);
    int b   = pos % (9 + s);
    logic [31:0] v = f;
    if (b == 0) return 1'b0;
    if (b <= 8) return v[24 - 8 * byt + (b - 1)];
    return 1'b1;
  endfunction

  task automatic chk_all(input bit sel, input string tag, input logic e_tx, input logic e_busy,
                         input logic e_sent, input logic e_ovr);
    chk({tag, ".tx"},         32'(o_tx(sel)),   32'(e_tx));
    chk({tag, ".busy"},       32'(o_busy(sel)), 32'(e_busy));
    chk({tag, ".frame_sent"}, 32'(o_sent(sel)), 32'(e_sent));
    chk({tag, ".overrun"},    32'(o_ovr(sel)),  32'(e_ovr));
  endtask

  // Accept a frame, then check every line cycle. Negative offsets disable the event.
  task automatic run_frame(input bit sel, input logic [31:0] f, input int tick_at,
                           input int chg_at, input int rst_at);
    int          s   = sel ? 2 : 1;
    int          len = 4 * (9 + s) * CPB;
    logic        ovr_exp = 1'b0;
    logic        tk, en;
    logic [31:0] fi;
    logic [31:0] rx = '0;
    drive(sel, 1'b1, 1'b1, f);
    cyc();
    for (int k = 0; k < len; k++) begin
      chk_all(sel, "frame", exp_bit(f, k, s), 1'b1, 1'b0, ovr_exp);
      if ((k % CPB) == CPB / 2) begin
        int pos = k / CPB;
        int b   = pos % (9 + s);
        if (b >= 1 && b <= 8) rx[24 - 8 * (pos / (9 + s)) + (b - 1)] = o_tx(sel);
      end
      if (k == rst_at) begin
        drive(sel, 1'b0, 1'b1, f);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_all(sel, "mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < len; j++) begin
          cyc();
          chk_all(sel, "after_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        return;
      end
      tk = (k == tick_at);
      en = !(chg_at >= 0 && k >= chg_at);
      fi = (chg_at >= 0 && k >= chg_at) ? 32'h0 : f;
      drive(sel, tk, en, fi);
      ovr_exp = tk && en;
      cyc();
    end
    chk_all(sel, "end", 1'b1, 1'b0, 1'b1, ovr_exp);
    chk("rx_buf", rx, f);
    drive(sel, 1'b0, 1'b1, f);
  endtask

  // Idle cycles with ticks offered while enable is low: nothing may start.
  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      drive(sel, 1'($urandom_range(0, 1)), 1'b0, $urandom);
      cyc();
      chk_all(sel, "idle", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(sel, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all(1'b0, "reset1", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_all(1'b1, "reset2", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    idle(1'b0, 3);

    // Basic frame, then overrun tick at cycle 50 with a back-to-back follow-up frame.
    run_frame(1'b0, 32'hA5C3_0F81, -1, -1, -1);
    run_frame(1'b0, 32'hA5C3_0F81, 50, -1, -1);
    run_frame(1'b0, 32'h1234_5678, 4 * 10 * CPB - 1, -1, -1);
    // frame_in zeroed and enable dropped mid-frame; a tick under enable=0 is ignored.
    run_frame(1'b0, 32'hA5C3_0F81, 60, 30, -1);
    idle(1'b0, 2);
    // Reset mid-frame, then a fresh complete frame.
    run_frame(1'b0, 32'hA5C3_0F81, -1, -1, 70);
    run_frame(1'b0, 32'hA5C3_0F81, -1, -1, -1);
    // Two stop bits.
    run_frame(1'b1, 32'hFFFF_FFFF, -1, -1, -1);
    run_frame(1'b1, 32'h8000_0001, 100, -1, -1);

    for (int r = 0; r < 8; r++) begin
      bit sel = 1'($urandom_range(0, 1));
      int lim = 4 * (9 + (sel ? 2 : 1)) * CPB;
      int ta  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, lim - 1));
      run_frame(sel, $urandom, ta, -1, -1);
      idle(sel, int'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
